// File: rtl/updown_count_monitor_pkg.sv
// Purpose : shared types and constants for the up/down counter monitor.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package updown_count_monitor_pkg;

    localparam int DEF_WIDTH         = 3;
    localparam int DEF_STABLE_CYCLES = 2;
    localparam int DEF_WRAP_W        = 8;

    // Counter mode line encoding
    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_TRACK = 2'd1,
        S_FAULT = 2'd2
    } mon_state_e;

endpackage

// File: rtl/updown_count_monitor_if.sv
// Purpose : raw counter bus (Q outputs + mode line) as seen by the monitor.
// Latency : n/a (wires only).
// Backpressure: none; the counter free-runs and the monitor only observes.
//   q_in : raw counter outputs, asynchronous to the monitor clock
//   m_in : counter mode, 0 = up, 1 = down
interface updown_count_monitor_if
    import updown_count_monitor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] q_in;
    logic             m_in;

    modport master (output q_in, output m_in);
    modport slave  (input  q_in, input  m_in);
endinterface

// File: rtl/updown_count_monitor_count_stable_filter.sv
// Purpose : 2-flop synchronizer plus run-length stability filter for a bus.
// Latency : accept strobe STABLE_CYCLES+1 edges after the first edge that samples a new value.
// Backpressure: none; strobe is a combinational one-cycle pulse the parent must consume.
//   clk, clr      : clock and synchronous active-high clear
//   d_in          : asynchronous input bus
//   acc_vld       : high for the one edge where the synchronized value completes its run
//   acc_dat       : value being accepted (synchronized sample)
module count_stable_filter
    import updown_count_monitor_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_in,
    output logic             acc_vld,
    output logic [WIDTH-1:0] acc_dat
);

    localparam int CNT_W = (STABLE_CYCLES < 1) ? 1 : $clog2(STABLE_CYCLES + 1);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] hold_q,  hold_d;
    logic [CNT_W-1:0] stab_q,  stab_d;
    // Pipeline fill after clear: 2 means sync2 holds a real sample, 3 means hold does too.
    // Cleared flops must not masquerade as a stable run of zeros.
    logic [1:0]       fill_q,  fill_d;
    logic             equal;

    always_comb begin
        sync1_d = d_in;
        sync2_d = sync1_q;
        hold_d  = sync2_q;
        fill_d  = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;

        equal = (fill_q == 2'd3) && (sync2_q == hold_q);

        // stab counts consecutive equal comparisons; a run of S samples holds S-1 of them
        if (!equal) begin
            stab_d = '0;
        end else if (stab_q == CNT_W'(STABLE_CYCLES)) begin
            stab_d = stab_q;
        end else begin
            stab_d = stab_q + CNT_W'(1);
        end

        acc_vld = (fill_q >= 2'd2) && (stab_d == CNT_W'(STABLE_CYCLES - 1));
        acc_dat = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sync1_q <= '0;
            sync2_q <= '0;
            hold_q  <= '0;
            stab_q  <= '0;
            fill_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            hold_q  <= hold_d;
            stab_q  <= stab_d;
            fill_q  <= fill_d;
        end
    end

endmodule

// File: rtl/updown_count_monitor.sv
// Purpose : classify settled counter changes as up/down steps or illegal jumps; track wraps.
// Latency : count_q and pulses update STABLE_CYCLES+2 edges after q_in first settles (4 by default).
// Backpressure: none; pulses are one cycle wide and must be consumed when seen.
//   clk, clr            : clock, synchronous active-high clear
//   cnt_if (slave)      : raw counter q_in / m_in
//   count_q/count_valid : last accepted count and its valid flag
//   ext_count/wrap_cnt  : {wrap_cnt, count_q} and signed net wrap count
//   step_up/step_down/wrap_pulse : one-cycle event pulses
//   err_step/err_dir    : sticky protocol error flags
module updown_count_monitor
    import updown_count_monitor_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int WRAP_W        = DEF_WRAP_W
) (
    input  logic                    clk,
    input  logic                    clr,
    updown_count_monitor_if.slave   cnt_if,
    output logic [WIDTH-1:0]        count_q,
    output logic                    count_valid,
    output logic [WRAP_W+WIDTH-1:0] ext_count,
    output logic [WRAP_W-1:0]       wrap_cnt,
    output logic                    step_up,
    output logic                    step_down,
    output logic                    wrap_pulse,
    output logic                    err_step,
    output logic                    err_dir
);

    logic             acc_vld;
    logic [WIDTH-1:0] acc_dat;

    count_stable_filter #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_q_filter (
        .clk     (clk),
        .clr     (clr),
        .d_in    (cnt_if.q_in),
        .acc_vld (acc_vld),
        .acc_dat (acc_dat)
    );

    mon_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_d;
    logic             count_valid_q, count_valid_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             step_up_q, step_up_d;
    logic             step_down_q, step_down_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             err_step_q, err_step_d;
    logic             err_dir_q, err_dir_d;
    // Mode sync is aligned with the q filter's sync2 stage, so both describe the same sample
    logic             m_sync1_q, m_sync1_d;
    logic             m_sync2_q, m_sync2_d;

    logic [WIDTH-1:0] diff;
    logic             new_val;

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        count_valid_d = count_valid_q;
        wrap_cnt_d    = wrap_cnt_q;
        step_up_d     = 1'b0;
        step_down_d   = 1'b0;
        wrap_pulse_d  = 1'b0;
        err_step_d    = err_step_q;
        err_dir_d     = err_dir_q;
        m_sync1_d     = cnt_if.m_in;
        m_sync2_d     = m_sync1_q;

        diff    = acc_dat - count_q;
        // The first acceptance after clear loads even a value equal to the cleared count
        new_val = acc_vld && ((state_q == S_INIT) || (acc_dat != count_q));

        if (new_val) begin
            count_d = acc_dat;
            case (state_q)
                S_INIT: begin
                    count_valid_d = 1'b1;
                    state_d       = S_TRACK;
                end
                S_TRACK: begin
                    if (diff == WIDTH'(1)) begin
                        step_up_d = 1'b1;
                        if (count_q == {WIDTH{1'b1}}) begin
                            wrap_pulse_d = 1'b1;
                            wrap_cnt_d   = wrap_cnt_q + WRAP_W'(1);
                        end
                        if (m_sync2_q == MODE_DOWN) begin
                            err_dir_d = 1'b1;
                        end
                    end else if (diff == {WIDTH{1'b1}}) begin
                        step_down_d = 1'b1;
                        if (count_q == '0) begin
                            wrap_pulse_d = 1'b1;
                            wrap_cnt_d   = wrap_cnt_q - WRAP_W'(1);
                        end
                        if (m_sync2_q == MODE_UP) begin
                            err_dir_d = 1'b1;
                        end
                    end else begin
                        err_step_d = 1'b1;
                        state_d    = S_FAULT;
                    end
                end
                default: begin
                    // S_FAULT: follow the count only; wrap and pulses stay frozen
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q       <= S_INIT;
            count_q       <= '0;
            count_valid_q <= 1'b0;
            wrap_cnt_q    <= '0;
            step_up_q     <= 1'b0;
            step_down_q   <= 1'b0;
            wrap_pulse_q  <= 1'b0;
            err_step_q    <= 1'b0;
            err_dir_q     <= 1'b0;
            m_sync1_q     <= 1'b0;
            m_sync2_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            count_valid_q <= count_valid_d;
            wrap_cnt_q    <= wrap_cnt_d;
            step_up_q     <= step_up_d;
            step_down_q   <= step_down_d;
            wrap_pulse_q  <= wrap_pulse_d;
            err_step_q    <= err_step_d;
            err_dir_q     <= err_dir_d;
            m_sync1_q     <= m_sync1_d;
            m_sync2_q     <= m_sync2_d;
        end
    end

    assign count_valid = count_valid_q;
    assign wrap_cnt    = wrap_cnt_q;
    assign ext_count   = {wrap_cnt_q, count_q};
    assign step_up     = step_up_q;
    assign step_down   = step_down_q;
    assign wrap_pulse  = wrap_pulse_q;
    assign err_step    = err_step_q;
    assign err_dir     = err_dir_q;

endmodule
